ram_line_arbiter: RTL and testbench

RAM_LINE_ARBITER -- requirements
Module: ram_line_arbiter

---
 rtl/ram_line_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ram_line_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_line_arbiter.sv
// Two-port (instruction/data) line arbiter in front of a single-ported line RAM.
// One RAM operation at a time. Ties go round-robin, with data winning first after reset.
// Optional macro RAM_ARB_STATS_EN enables saturating per-port grant counters.
module ram_line_arbiter #(
    parameter int unsigned WORD_WIDTH       = 32,
    parameter int unsigned RAM_DEPTH        = 32768,
    parameter int unsigned CACHE_LINE_WIDTH = 128,
    localparam int unsigned ADDR_W          = $clog2(RAM_DEPTH),
    localparam int unsigned W               = CACHE_LINE_WIDTH / WORD_WIDTH,
    localparam int unsigned LB              = $clog2(W)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            i_req_i,
    input  logic [31:0]                     i_addr_i,
    output logic                            i_gnt_o,
    output logic                            i_rvalid_o,
    output logic [CACHE_LINE_WIDTH-1:0]     i_rdata_o,
    input  logic                            d_req_i,
    input  logic                            d_we_i,
    input  logic [31:0]                     d_addr_i,
    input  logic [CACHE_LINE_WIDTH-1:0]     d_wdata_i,
    input  logic [CACHE_LINE_WIDTH/8-1:0]   d_wstrb_i,
    output logic                            d_gnt_o,
    output logic                            d_rvalid_o,
    output logic [CACHE_LINE_WIDTH-1:0]     d_rdata_o,
    output logic [ADDR_W-1:0]               ram_addr_o,
    output logic [CACHE_LINE_WIDTH-1:0]     ram_wdata_o,
    output logic [CACHE_LINE_WIDTH/8-1:0]   ram_wstrb_o,
    output logic                            ram_rd_en_o,
    input  logic [CACHE_LINE_WIDTH-1:0]     ram_rdata_i,
    output logic [31:0]                     i_grant_cnt_o,
    output logic [31:0]                     d_grant_cnt_o
);

    localparam int unsigned CW = (LB > 0) ? LB : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LB) - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           last_d_q;
    logic                           port_d_q;
    logic                           we_q;
    logic [ADDR_W-1:0]              addr_q;
    logic [CACHE_LINE_WIDTH-1:0]    wdata_q;
    logic [CACHE_LINE_WIDTH/8-1:0]  wstrb_q;

    logic                           pick_i, pick_d;
    logic                           gnt_i_d, gnt_d_d;
    logic                           rvalid_i_d, rvalid_d_d;
    logic                           rd_en_d;
    logic [CACHE_LINE_WIDTH/8-1:0]  wstrb_d;
    logic [CACHE_LINE_WIDTH-1:0]    wdata_d;
    logic [31:0]                    sel_addr;
    logic [ADDR_W-1:0]              line_addr;
    logic                           unused_addr_bits;

    assign pick_d    = d_req_i && (!i_req_i || !last_d_q);
    assign pick_i    = i_req_i && !pick_d;
    assign sel_addr  = gnt_d_d ? d_addr_i : i_addr_i;
    assign line_addr = sel_addr[ADDR_W+1:2] & LINE_MASK;
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};
    assign ram_addr_o = addr_q;

    // Grant decisions are made one cycle ahead so gnt/rd_en/wstrb/rvalid come out of flops;
    // IDLE with a gnt already showing is the grant cycle itself and moves straight to ISSUE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_i_d    = 1'b0;
        gnt_d_d    = 1'b0;
        rvalid_i_d = 1'b0;
        rvalid_d_d = 1'b0;
        rd_en_d    = 1'b0;
        wstrb_d    = '0;
        wdata_d    = '0;
        case (state_q)
            IDLE: begin
                if (i_gnt_o || d_gnt_o) begin
                    state_d = ISSUE;
                    rd_en_d = !we_q;
                    if (we_q) begin
                        wstrb_d = wstrb_q;
                        wdata_d = wdata_q;
                    end
                end else begin
                    gnt_i_d = pick_i;
                    gnt_d_d = pick_d;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == CW'(W - 1)) begin
                    state_d    = RESP;
                    rvalid_i_d = !port_d_q;
                    rvalid_d_d = port_d_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt_i_d = pick_i;
                gnt_d_d = pick_d;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the winner's request payload and remember who won for round-robin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_d_q <= 1'b0;
            port_d_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (gnt_i_d || gnt_d_d) begin
            last_d_q <= gnt_d_d;
            port_d_q <= gnt_d_d;
            we_q     <= gnt_d_d && d_we_i;
            addr_q   <= line_addr;
            wdata_q  <= gnt_d_d ? d_wdata_i : '0;
            wstrb_q  <= gnt_d_d ? d_wstrb_i : '0;
        end
    end

    // Registered handshake, RAM control and read-data capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_gnt_o     <= 1'b0;
            d_gnt_o     <= 1'b0;
            i_rvalid_o  <= 1'b0;
            d_rvalid_o  <= 1'b0;
            ram_rd_en_o <= 1'b0;
            ram_wstrb_o <= '0;
            ram_wdata_o <= '0;
            i_rdata_o   <= '0;
            d_rdata_o   <= '0;
        end else begin
            i_gnt_o     <= gnt_i_d;
            d_gnt_o     <= gnt_d_d;
            i_rvalid_o  <= rvalid_i_d;
            d_rvalid_o  <= rvalid_d_d;
            ram_rd_en_o <= rd_en_d;
            ram_wstrb_o <= wstrb_d;
            ram_wdata_o <= wdata_d;
            if (rvalid_i_d) begin
                i_rdata_o <= ram_rdata_i;
            end
            if (rvalid_d_d && !we_q) begin
                d_rdata_o <= ram_rdata_i;
            end
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [31:0] i_cnt_q, d_cnt_q;

    // Saturating grant counters, stepped on the same edge that raises gnt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            if (gnt_i_d && (i_cnt_q != '1)) i_cnt_q <= i_cnt_q + 32'd1;
            if (gnt_d_d && (d_cnt_q != '1)) d_cnt_q <= d_cnt_q + 32'd1;
        end
    end

    assign i_grant_cnt_o = i_cnt_q;
    assign d_grant_cnt_o = d_cnt_q;
`else
    assign i_grant_cnt_o = '0;
    assign d_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ram_line_arbiter.sv
// Bench for ram_line_arbiter: vector table plus hand-written tie and reset sequences,
// with a response scoreboard and a behavioural line RAM.
module tb_ram_line_arbiter;

    localparam int unsigned W = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          i_req_i = 1'b0;
    logic [31:0]   i_addr_i = '0;
    logic          i_gnt_o, i_rvalid_o;
    logic [127:0]  i_rdata_o;
    logic          d_req_i = 1'b0;
    logic          d_we_i = 1'b0;
    logic [31:0]   d_addr_i = '0;
    logic [127:0]  d_wdata_i = '0;
    logic [15:0]   d_wstrb_i = '0;
    logic          d_gnt_o, d_rvalid_o;
    logic [127:0]  d_rdata_o;
    logic [14:0]   ram_addr_o;
    logic [127:0]  ram_wdata_o;
    logic [15:0]   ram_wstrb_o;
    logic          ram_rd_en_o;
    logic [127:0]  ram_rdata_i = '0;
    logic [31:0]   i_grant_cnt_o, d_grant_cnt_o;

    ram_line_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_wstrb_o(ram_wstrb_o),
        .ram_rd_en_o(ram_rd_en_o), .ram_rdata_i(ram_rdata_i),
        .i_grant_cnt_o(i_grant_cnt_o), .d_grant_cnt_o(d_grant_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int exp_i_cnt = 0;
    int exp_d_cnt = 0;

    typedef struct {
        logic          port_d;
        logic          chk_data;
        logic [127:0]  data;
        int            t_resp;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    typedef struct {
        logic          port_d;
        logic          we;
        logic [31:0]   addr;
        logic [127:0]  wdata;
        logic [15:0]   wstrb;
        logic [14:0]   exp_addr;
        logic [127:0]  exp_rdata;
    } vec_t;
    vec_t tv[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Line RAM: word k of line n starts as {C0DE, n, k}; registered read, byte-strobed write
    logic [127:0] mem [0:63];
    logic mem_ready = 1'b0;
    always @(posedge clk_i) begin
        if (!mem_ready) begin
            for (int n = 0; n < 64; n++)
                for (int k = 0; k < 4; k++)
                    mem[n][k*32 +: 32] <= {16'hC0DE, 8'(n), 8'(k)};
            mem_ready <= 1'b1;
        end else begin
            if (ram_rd_en_o) ram_rdata_i <= mem[ram_addr_o[7:2]];
            for (int b = 0; b < 16; b++)
                if (ram_wstrb_o[b]) mem[ram_addr_o[7:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
        end
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    // Response monitor: pulse counting and scoreboard pop on rvalid
    always @(negedge clk_i) begin
        if (ram_rd_en_o) rd_pulses++;
        if (|ram_wstrb_o) wr_pulses++;
        if (i_rvalid_o || d_rvalid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 128'({i_rvalid_o, d_rvalid_o}), 128'(0));
            end else begin
                me = sb.pop_front();
                check("resp_port", 128'({i_rvalid_o, d_rvalid_o}), me.port_d ? 128'(1) : 128'(2));
                check("resp_cycle", 128'(cyc), 128'(me.t_resp));
                if (me.chk_data)
                    check("resp_data", me.port_d ? d_rdata_o : i_rdata_o, me.data);
            end
        end
    end

    task automatic drain(input string tag);
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk_i);
        end
        check({tag, "_drain"}, 128'(sb.size()), 128'(0));
        sb.delete();
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_gnt"}, 128'({i_gnt_o, d_gnt_o}), 128'(0));
        check({tag, "_rvalid"}, 128'({i_rvalid_o, d_rvalid_o}), 128'(0));
        check({tag, "_ram_ctl"}, 128'({ram_rd_en_o, ram_wstrb_o, ram_addr_o}), 128'(0));
        check({tag, "_ram_wdata"}, ram_wdata_o, 128'(0));
        check({tag, "_rdata"}, i_rdata_o | d_rdata_o, 128'(0));
        check({tag, "_cnt"}, 128'({i_grant_cnt_o, d_grant_cnt_o}), 128'(0));
    endtask

    task automatic do_txn(input int id, input vec_t v);
        int lat;
        int rd0;
        int wr0;
        exp_t e;
        string t;
        t = $sformatf("t%0d", id);
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        lat = 0;
        if (v.port_d) begin
            d_req_i = 1'b1; d_we_i = v.we; d_addr_i = v.addr;
            d_wdata_i = v.wdata; d_wstrb_i = v.wstrb;
        end else begin
            i_req_i = 1'b1; i_addr_i = v.addr;
        end
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk_i);
            if (v.port_d ? d_gnt_o : i_gnt_o) begin
                lat = n;
                break;
            end
        end
        i_req_i = 1'b0; i_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
        check({t, "_gnt_latency"}, 128'(lat), 128'(1));
        if (lat == 0) return;
        check({t, "_other_gnt"}, 128'(v.port_d ? i_gnt_o : d_gnt_o), 128'(0));
        e.port_d = v.port_d;
        e.chk_data = !v.we;
        e.data = v.exp_rdata;
        e.t_resp = cyc + W + 2;
        sb.push_back(e);
        if (v.port_d) exp_d_cnt++; else exp_i_cnt++;
        @(negedge clk_i);
        check({t, "_gnt_pulse"}, 128'({i_gnt_o, d_gnt_o}), 128'(0));
        check({t, "_rd_en"}, 128'(ram_rd_en_o), 128'(!v.we));
        check({t, "_wstrb"}, 128'(ram_wstrb_o), v.we ? 128'(v.wstrb) : 128'(0));
        check({t, "_ram_addr"}, 128'(ram_addr_o), 128'(v.exp_addr));
        check({t, "_ram_wdata"}, ram_wdata_o, v.we ? v.wdata : 128'(0));
        drain(t);
        check({t, "_rd_pulses"}, 128'(rd_pulses - rd0), 128'(!v.we));
        check({t, "_wr_pulses"}, 128'(wr_pulses - wr0), 128'((v.we && (v.wstrb != 0)) ? 1 : 0));
    endtask

    // Both ports request together: data must win, instruction follows at T0+7
    task automatic tie(input string tag);
        int t0;
        bit got;
        exp_t e;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0;
        i_req_i = 1'b1; i_addr_i = 32'h10;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (i_gnt_o || d_gnt_o) break;
        end
        check({tag, "_d_first"}, 128'({i_gnt_o, d_gnt_o}), 128'(1));
        t0 = cyc;
        e.port_d = 1'b1; e.chk_data = 1'b1; e.t_resp = t0 + W + 2;
        e.data = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
        sb.push_back(e);
        exp_d_cnt++;
        d_req_i = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (i_gnt_o) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_i_cycle"}, 128'(cyc), 128'(t0 + W + 3));
        i_req_i = 1'b0; i_addr_i = '0;
        if (got) begin
            e.port_d = 1'b0; e.t_resp = cyc + W + 2;
            e.data = 128'hC0DE0103_C0DE0102_C0DE0101_C0DE0100;
            sb.push_back(e);
            exp_i_cnt++;
        end
        drain(tag);
    endtask

    task automatic check_counts(input string tag);
`ifdef RAM_ARB_STATS_EN
        check({tag, "_i_cnt"}, 128'(i_grant_cnt_o), 128'(exp_i_cnt));
        check({tag, "_d_cnt"}, 128'(d_grant_cnt_o), 128'(exp_d_cnt));
`else
        check({tag, "_i_cnt"}, 128'(i_grant_cnt_o), 128'(0));
        check({tag, "_d_cnt"}, 128'(d_grant_cnt_o), 128'(0));
`endif
    endtask

    initial begin
        int t0;
        tv[0] = '{1'b0, 1'b0, 32'h10, '0, '0, 15'd4, 128'hC0DE0103_C0DE0102_C0DE0101_C0DE0100};
        tv[1] = '{1'b1, 1'b0, 32'h00, '0, '0, 15'd0, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000};
        tv[2] = '{1'b1, 1'b1, 32'h20, {16{8'hA5}}, 16'h000F, 15'd8, '0};
        tv[3] = '{1'b1, 1'b0, 32'h20, '0, '0, 15'd8, 128'hC0DE0203_C0DE0202_C0DE0201_A5A5A5A5};
        tv[4] = '{1'b0, 1'b0, 32'h2C, '0, '0, 15'd8, 128'hC0DE0203_C0DE0202_C0DE0201_A5A5A5A5};
        tv[5] = '{1'b1, 1'b1, 32'h30, {16{8'hFF}}, 16'h0000, 15'd12, '0};
        tv[6] = '{1'b1, 1'b0, 32'h30, '0, '0, 15'd12, 128'hC0DE0303_C0DE0302_C0DE0301_C0DE0300};
        tv[7] = '{1'b1, 1'b1, 32'h40, 128'h11111111_22222222_33333333_44444444, 16'hF0F0, 15'd16, '0};
        tv[8] = '{1'b1, 1'b0, 32'h40, '0, '0, 15'd16, 128'h11111111_C0DE0402_33333333_C0DE0400};
        tv[9] = '{1'b0, 1'b0, 32'h0002_0040, '0, '0, 15'd16, 128'h11111111_C0DE0402_33333333_C0DE0400};

        repeat (3) @(negedge clk_i);
        check_zero_outs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        tie("tie1");
        tie("tie2");

        for (int i = 0; i < 10; i++) do_txn(i, tv[i]);

        do_txn(10, tv[1]);
        check("i_rdata_hold", i_rdata_o, tv[9].exp_rdata);
        check("d_rdata_last", d_rdata_o, tv[1].exp_rdata);
        check_counts("stats_run");

        // Abort a read with reset at T0+3
        i_req_i = 1'b1; i_addr_i = 32'h10;
        t0 = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk_i);
            if (i_gnt_o) begin
                t0 = n;
                break;
            end
        end
        i_req_i = 1'b0; i_addr_i = '0;
        check("abort_gnt_latency", 128'(t0), 128'(1));
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_zero_outs("abort");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        exp_i_cnt = 0;
        exp_d_cnt = 0;
        repeat (W + 4) @(negedge clk_i);
        check("abort_no_rvalid", 128'(sb.size()), 128'(0));

        do_txn(20, tv[0]);
        do_txn(21, tv[4]);
        do_txn(22, tv[9]);
        do_txn(23, tv[1]);
        do_txn(24, tv[3]);
        check_counts("stats_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
